tri_area_max_seq: RTL and testbench
===================================

// Module: tri_area_max_seq
// PURPOSE
//  Sequential, parametrised right-triangle area comparator.
//  - Accepts a stream of triangles (leg_a, leg_b, hyp) grouped into frames by in_last.
//  - Computes area = floor(leg_a*leg_b/2) with a shift-add multiplier.
//  - At frame end, reports the max area, its hypotenuse and its index within the frame.
//  - Drop-in front end for the area datapath; replaces the fixed two-triangle combinational compare.
// PARAMETERS
//  W      9  leg/hypotenuse width in bits (unsigned)
//  IDX_W  4  width of the triangle index within a frame
//  Derived (localparam): AW = 2*W-1, the area width.
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      triangle input valid
//  in_ready   out  1      block can accept a triangle
//  in_leg_a   in   W      first leg
//  in_leg_b   in   W      second leg
//  in_hyp     in   W      hypotenuse; passed through, never checked
//  in_last    in   1      this triangle closes the frame
//  out_valid  out  1      frame result valid
//  out_ready  in   1      consumer accepts the result
//  out_area   out  AW     max floor(a*b/2) in the frame
//  out_hyp    out  W      hyp of the max-area triangle
//  out_idx    out  IDX_W  0-based index of the max-area triangle
//  out_cnt    out  IDX_W  triangles in the frame minus 1
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1, out_valid=0; out_area/out_hyp/out_idx/out_cnt=0; max and count regs cleared.
//  - rst wins over every other event in the same cycle. Reset mid-MUL or mid-DONE discards the frame silently.
//  - Handshakes: a transfer occurs when valid&&ready are high at a clk edge.
//    Data must stay stable while valid is high and ready is low.
//  - FSM states: IDLE, MUL, CMP, DONE.
//    IDLE: in_ready=1. An input transfer latches the operands and in_last, clears the accumulator, goes to MUL.
//    MUL:  exactly W cycles of radix-2 shift-add, LSB of leg_b first; in_ready=0.
//    CMP:  one cycle.
//      area = product[2W-1:1] (drop the LSB).
//      Update max only if area > max; a tie keeps the earlier triangle.
//      The first triangle of a frame always loads the max.
//      Next state: DONE if in_last was latched, else IDLE.
//      Frame counter increments; it saturates at 2^IDX_W-1.
//      Once saturated, later winners record the saturated index.
//    DONE: out_valid=1 and out_* are held stable. in_ready=0 (no pipelining across frames).
//      On an out_ready transfer: clear max and count, go to IDLE. The next cycle has out_valid=0.
//  - Latency: input accepted at edge t -> CMP during cycle t+W+1 -> in_ready high again (or out_valid high) from edge t+W+2.
//    Throughput: one triangle per W+2 cycles.
//  - Width: the product is 2W bits and cannot overflow; the comparison is unsigned over AW bits.
//  - Zero legs are legal and give area 0.
//  - A single-triangle frame (in_last on the first triangle) reports idx=0, cnt=0.
// STRUCTURE
//  - Shared include tri_pkg.vh holds:
//    - FSM state encodings ST_IDLE, ST_MUL, ST_CMP, ST_DONE (2-bit);
//    - the AW derivation macro;
//    - the MUL step-counter width, clog2(W+1).
//  - Sub-module tri_mul_seq: W-bit sequential shift-add multiplier.
//    Ports: clk, rst, start, a, b -> busy, done, prod[2W-1:0].
//    The parent FSM sequences start/done. Compare/mux logic stays in the parent.
// TESTING  (default W=9, IDX_W=4)
//  1. Frame (3,4,5),(6,8,10,last) -> out_area=24, out_hyp=10, out_idx=1, out_cnt=1.
//  2. Tie: (4,6,7),(3,8,9,last), both area 12 -> out_area=12, out_hyp=7, out_idx=0.
//  3. Odd product: single (5,7,9,last) -> out_area=17, out_idx=0, out_cnt=0.
//     Also check that in_ready is low for exactly W+1=10 cycles after acceptance.
//  4. Max operands (511,511,100,last) -> out_area=130560, no overflow.
//     Then (0,300,1,last) -> out_area=0.
//  5. Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0.
//     in_valid held high is not accepted until one cycle after the out transfer.
//  6. Reset mid-MUL (cycle 4 of 9) of the 2nd triangle -> next cycle: out_valid=0, in_ready=1.
//     A following frame (2,2,3,last) reports area=2, idx=0; no stale max.

Source files
------------

// File: rtl/tri_area_max_seq_pkg.sv
// Shared types and width helpers for the right-triangle area comparator.
// Holds the FSM encoding and the area / step-counter width derivations.
package tri_area_max_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int area_w_f(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int step_w_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/tri_area_max_seq_mul.sv
// W-bit radix-2 shift-add multiplier, multiplier LSB first.
// start loads operands; done is high during the final step cycle.
module tri_area_max_seq_mul
    import tri_area_max_seq_pkg::*;
#(
    parameter int W = 9,
    localparam int CW = step_w_f(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mc_q, mc_d;
    logic [W-1:0]   mp_q, mp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           last_step;

    assign last_step = busy_q && (cnt_q == CW'(W - 1));

    always_comb begin
        acc_d  = acc_q;
        mc_d   = mc_q;
        mp_d   = mp_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start) begin
            acc_d  = '0;
            mc_d   = {{W{1'b0}}, a};
            mp_d   = b;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (mp_q[0]) begin
                acc_d = acc_q + mc_q;
            end
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mc_q   <= mc_d;
            mp_q   <= mp_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = last_step;
    assign prod = acc_q;

endmodule

// File: rtl/tri_area_max_seq.sv
// Streams right triangles, framed by in_last, and reports the
// max floor(a*b/2) area with its hypotenuse and index per frame.
module tri_area_max_seq
    import tri_area_max_seq_pkg::*;
#(
    parameter int W     = 9,
    parameter int IDX_W = 4,
    localparam int AW   = area_w_f(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_leg_a,
    input  logic [W-1:0]     in_leg_b,
    input  logic [W-1:0]     in_hyp,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_area,
    output logic [W-1:0]     out_hyp,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_cnt
);

    state_e           state_q, state_d;
    logic [W-1:0]     hyp_q, hyp_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic [AW-1:0]    max_q, max_d;
    logic [W-1:0]     mhyp_q, mhyp_d;
    logic [IDX_W-1:0] midx_q, midx_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [2*W-1:0]   mul_prod;
    logic [2*W-1:0]   area_w;
    logic             upd;

    tri_area_max_seq_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (in_leg_a),
        .b     (in_leg_b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    // Dropping the product LSB gives floor(a*b/2).
    assign area_w = mul_prod >> 1;
    assign upd    = first_q || (area_w > {1'b0, max_q});

    assign in_ready  = (state_q == ST_IDLE) && !mul_busy;
    assign out_valid = (state_q == ST_DONE);
    assign mul_start = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        hyp_d   = hyp_q;
        last_d  = last_q;
        first_d = first_q;
        max_d   = max_q;
        mhyp_d  = mhyp_q;
        midx_d  = midx_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    hyp_d   = in_hyp;
                    last_d  = in_last;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (upd) begin
                    max_d  = area_w[AW-1:0];
                    mhyp_d = hyp_q;
                    midx_d = idx_q;
                end
                cnt_d   = idx_q;
                first_d = 1'b0;
                if (idx_q != {IDX_W{1'b1}}) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                state_d = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    max_d   = '0;
                    mhyp_d  = '0;
                    midx_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hyp_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
            max_q   <= '0;
            mhyp_q  <= '0;
            midx_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hyp_q   <= hyp_d;
            last_q  <= last_d;
            first_q <= first_d;
            max_q   <= max_d;
            mhyp_q  <= mhyp_d;
            midx_q  <= midx_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_area = max_q;
    assign out_hyp  = mhyp_q;
    assign out_idx  = midx_q;
    assign out_cnt  = cnt_q;

endmodule

// File: tb/tb_tri_area_max_seq.sv
// Directed bench for tri_area_max_seq with hand-computed expectations.
module tb_tri_area_max_seq;

    localparam int W     = 9;
    localparam int IDX_W = 4;
    localparam int AW    = 2 * W - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_leg_a = '0;
    logic [W-1:0]     in_leg_b = '0;
    logic [W-1:0]     in_hyp = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [AW-1:0]    out_area;
    logic [W-1:0]     out_hyp;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W-1:0] out_cnt;

    int total = 0;
    int bad   = 0;

    tri_area_max_seq #(.W(W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_leg_a  (in_leg_a),
        .in_leg_b  (in_leg_b),
        .in_hyp    (in_hyp),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_area  (out_area),
        .out_hyp   (out_hyp),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a triangle and hold it until accepted (bounded).
    task automatic send(input int a, input int b, input int h, input bit last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_leg_a = W'(a);
        in_leg_b = W'(b);
        in_hyp   = W'(h);
        in_last  = last;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("out_valid_seen", ok, 1);
    endtask

    task automatic result(input string tag, input int area, input int hyp,
                          input int idx, input int cnt);
        wait_out();
        chk({tag, "_area"}, out_area, area);
        chk({tag, "_hyp"}, out_hyp, hyp);
        chk({tag, "_idx"}, out_idx, idx);
        chk({tag, "_cnt"}, out_cnt, cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, out_valid, 0);
    endtask

    initial begin
        int n;
        logic [AW-1:0] held;

        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_area", out_area, 0);
        chk("rst_hyp", out_hyp, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_cnt", out_cnt, 0);
        rst = 1'b0;
        tick();

        // Frame 1, plus busy-window length for a non-final triangle
        send(3, 4, 5, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) break;
            n++;
            tick();
        end
        chk("t1_busy_cycles", n, W + 1);
        send(6, 8, 10, 1);
        result("t1", 24, 10, 1, 1);

        // Tie keeps the earlier triangle
        send(4, 6, 7, 0);
        send(3, 8, 9, 1);
        result("t2", 12, 7, 0, 1);

        // Odd product, latency to out_valid
        send(5, 7, 9, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            n++;
            tick();
        end
        chk("t3_latency", n, W + 1);
        result("t3", 17, 9, 0, 0);

        // Max operands, then zero leg
        send(511, 511, 100, 1);
        result("t4a", 130560, 100, 0, 0);
        send(0, 300, 1, 1);
        result("t4b", 0, 1, 0, 0);

        // Backpressure in DONE with a new triangle already offered
        send(10, 20, 25, 1);
        wait_out();
        held     = out_area;
        chk("t5_area", held, 100);
        in_valid = 1'b1;
        in_leg_a = W'(7);
        in_leg_b = W'(9);
        in_hyp   = W'(11);
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", out_valid, 1);
            chk("t5_hold_area", out_area, held);
            chk("t5_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_post_ovalid", out_valid, 0);
        chk("t5_post_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_accepted", in_ready, 0);
        result("t5b", 31, 11, 0, 0);

        // Reset in the middle of the second multiply
        send(30, 40, 50, 0);
        send(6, 8, 10, 0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ovalid", out_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        send(2, 2, 3, 1);
        result("t6", 2, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
